conv_result_reader: RTL and testbench

CONV_RESULT_READER -- requirements
Module: conv_result_reader

---
 rtl/conv_result_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_conv_result_reader.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_reader.sv
// ---------------------------------------------------------------------------
// conv_result_reader
//
// Purpose:
//   After the convolution core signals completion, reads the result vector
//   out of Z-memory (addresses 0..N-1) and streams it to a valid/ready sink.
//   N is derived from the core config register when done_i is seen in IDLE.
//
// Optional feature:
//   RD_OVERRUN_EN - when defined, adds the sticky 'overrun' output, set by a
//                   done_i that arrives while a read-out is still active.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   data_ConfigReg   [0] shape (1 = same, 0 = full), [5:1] sizeX, [10:6] sizeY
//   done_i           completion pulse from the convolution core
//   memZ_addr/rd     Z-memory read address / read strobe
//   dataZ            Z-memory read data, valid the cycle after memZ_rd
//   out_data/valid   streamed sample and its valid flag
//   out_ready        sink ready
//   out_last         marks the sample read from address N-1
//   busy             high in READ, DRAIN and DONE
//   rd_done          one-cycle pulse in DONE
//   overrun          sticky overlap error (RD_OVERRUN_EN only)
//
// Handshake: a sample moves when out_valid && out_ready are both high at a
// rising clock edge. Once out_valid rises, out_data/out_last/out_valid hold
// until that transfer happens. Debug visibility of the FSM is via busy and
// rd_done, which are registered decodes of the state.
// ---------------------------------------------------------------------------
module conv_result_reader #(
    parameter int ADDR_WIDTH_MEMO = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                data_ConfigReg,
    input  logic                       done_i,
    output logic [ADDR_WIDTH_MEMO-1:0] memZ_addr,
    output logic                       memZ_rd,
    input  logic [15:0]                dataZ,
    output logic [15:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       rd_done
`ifdef RD_OVERRUN_EN
    ,
    output logic                       overrun
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [5:0]                 r_len;        // latched N
    logic [5:0]                 r_issue;      // next address to read
    logic [ADDR_WIDTH_MEMO-1:0] r_addr_hold;  // last issued address
    logic                       r_rd_q;       // dataZ carries a sample this cycle
    logic                       r_last_q;     // ... and it is from address N-1
    logic [1:0]                 r_cnt;        // buffered samples (0..2)
    logic [15:0]                r_b0_data;    // head entry (drives out_data)
    logic                       r_b0_last;
    logic [15:0]                r_b1_data;
    logic                       r_b1_last;
    logic                       r_busy;
    logic                       r_rd_done;

    logic                       w_shape;
    logic [4:0]                 w_size_x;
    logic [4:0]                 w_size_y;
    logic [5:0]                 w_len;
    logic                       w_xfer;
    logic                       w_is_last_rd;
    logic [2:0]                 w_credit;
    logic                       w_unused_cfg;

    assign w_shape      = data_ConfigReg[0];
    assign w_size_x     = data_ConfigReg[5:1];
    assign w_size_y     = data_ConfigReg[10:6];
    assign w_unused_cfg = ^data_ConfigReg[31:11];

    // Result length; full-shape maximum is 31 + 31 - 1 = 61, fits 6 bits.
    always_comb begin
        w_len = 6'd0;
        if (w_size_x == 5'd0 || w_size_y == 5'd0) begin
            w_len = 6'd0;
        end else if (w_shape) begin
            w_len = {1'b0, w_size_x};
        end else begin
            w_len = {1'b0, w_size_x} + {1'b0, w_size_y} - 6'd1;
        end
    end

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_b0_data;
    assign out_last  = r_b0_last && out_valid;
    assign w_xfer    = out_valid && out_ready;

    // Occupancy after this edge: current entries, plus the sample arriving
    // on dataZ, minus the one leaving. A new read is only allowed while that
    // stays below the buffer depth, and never with both entries already full,
    // so a stalled sink can never cause a returned sample to be dropped.
    assign w_credit     = {1'b0, r_cnt} + {2'b00, r_rd_q} - {2'b00, w_xfer};
    assign w_is_last_rd = (r_issue == r_len - 6'd1);
    assign memZ_rd      = (r_state == S_READ) && (r_cnt != 2'd2) &&
                          (w_credit < 3'd2);
    assign memZ_addr    = memZ_rd ? ADDR_WIDTH_MEMO'(r_issue) : r_addr_hold;

    assign busy    = r_busy;
    assign rd_done = r_rd_done;

    // Control FSM.
`ifdef RD_OVERRUN_EN
    logic r_overrun;
    assign overrun = r_overrun;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= 6'd0;
            r_issue     <= 6'd0;
            r_addr_hold <= '0;
            r_rd_q      <= 1'b0;
            r_last_q    <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_done   <= 1'b0;
`ifdef RD_OVERRUN_EN
            r_overrun   <= 1'b0;
`endif
        end else begin
            r_rd_done <= 1'b0;
            r_rd_q    <= memZ_rd;
            r_last_q  <= memZ_rd && w_is_last_rd;
            if (memZ_rd) begin
                r_issue     <= r_issue + 6'd1;
                r_addr_hold <= memZ_addr;
            end
`ifdef RD_OVERRUN_EN
            if (done_i && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (done_i) begin
                        r_len   <= w_len;
                        r_issue <= 6'd0;
                        r_busy  <= 1'b1;
                        if (w_len == 6'd0) begin
                            r_state   <= S_DONE;
                            r_rd_done <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (memZ_rd && w_is_last_rd) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && out_last) begin
                        r_state   <= S_DONE;
                        r_rd_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer, head in b0. Reset clears the in-flight flag
    // (r_rd_q above), so data from a read issued before reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 2'd0;
            r_b0_data <= 16'd0;
            r_b0_last <= 1'b0;
            r_b1_data <= 16'd0;
            r_b1_last <= 1'b0;
        end else begin
            case ({r_rd_q, w_xfer})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_b0_data <= dataZ;
                        r_b0_last <= r_last_q;
                    end else begin
                        r_b1_data <= dataZ;
                        r_b1_last <= r_last_q;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_b0_data <= r_b1_data;
                    r_b0_last <= r_b1_last;
                    r_cnt     <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_b0_data <= dataZ;
                        r_b0_last <= r_last_q;
                    end else begin
                        r_b0_data <= r_b1_data;
                        r_b0_last <= r_b1_last;
                        r_b1_data <= dataZ;
                        r_b1_last <= r_last_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// ---------------------------------------------------------------------------
// tb_conv_result_reader
//
// Bench for conv_result_reader with a Z-memory model (1-cycle read latency)
// and an expected-sample queue filled when each read-out is started.
// ---------------------------------------------------------------------------
module tb_conv_result_reader;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_ConfigReg;
    logic        done_i;
    logic [5:0]  memZ_addr;
    logic        memZ_rd;
    logic [15:0] dataZ;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        rd_done;
`ifdef RD_OVERRUN_EN
    logic        overrun;
`endif

    conv_result_reader #(.ADDR_WIDTH_MEMO(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_ConfigReg (data_ConfigReg),
        .done_i         (done_i),
        .memZ_addr      (memZ_addr),
        .memZ_rd        (memZ_rd),
        .dataZ          (dataZ),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .rd_done        (rd_done)
`ifdef RD_OVERRUN_EN
        ,
        .overrun        (overrun)
`endif
    );

    // Clock and memory model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:63];
    always @(posedge clk) begin
        if (memZ_rd) dataZ <= mem[memZ_addr];
    end

    // Scoreboard and bookkeeping.
    logic [16:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    int exp_addr = 0;
    int tb_occ   = 0;
    logic prev_rd = 1'b0;
    logic stall_prev = 1'b0;
    logic [17:0] stall_snap = '0;
    int rd_cnt, xfer_cnt, done_cnt, last_addr;
    int first_rd_t, first_valid_t, last_xfer_t, rd_done_t, busy_low_t;

    function automatic logic [31:0] cfg(input int x, input int y, input bit shape);
        return {21'd0, 5'(y), 5'(x), shape};
    endfunction

    task automatic clear_rec();
        rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; last_addr = -1;
        first_rd_t = -1; first_valid_t = -1; last_xfer_t = -1;
        rd_done_t = -1; busy_low_t = -1;
    endtask

    // One clock: sample mid-cycle, check the stream, then cross the edge.
    task automatic step();
        logic [16:0] exp_v;
        @(negedge clk);
        if (memZ_rd) begin
            total++;
            if (memZ_addr !== 6'(exp_addr)) begin
                bad++;
                $display("FAIL rd_addr: got %0d required %0d", memZ_addr, exp_addr);
            end
            total++;
            if (tb_occ >= 2) begin
                bad++;
                $display("FAIL rd_when_full: occupancy %0d required <2", tb_occ);
            end
            exp_addr++;
            rd_cnt++;
            last_addr = int'(memZ_addr);
            if (first_rd_t < 0) first_rd_t = cyc;
        end
        if (stall_prev) begin
            total++;
            if ({out_valid, out_last, out_data} !== stall_snap) begin
                bad++;
                $display("FAIL stall_hold: got %h required %h",
                         {out_valid, out_last, out_data}, stall_snap);
            end
        end
        if (out_valid && first_valid_t < 0) first_valid_t = cyc;
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sample_extra: got %h required none", {out_last, out_data});
            end else begin
                exp_v = exp_q.pop_front();
                if ({out_last, out_data} !== exp_v) begin
                    bad++;
                    $display("FAIL sample: got %h required %h", {out_last, out_data}, exp_v);
                end
            end
            xfer_cnt++;
            if (out_last) last_xfer_t = cyc;
        end
        if (rd_done) begin
            done_cnt++;
            rd_done_t = cyc;
        end
        if (!busy && busy_low_t < 0) busy_low_t = cyc;
        stall_prev = out_valid && !out_ready;
        stall_snap = {out_valid, out_last, out_data};
        tb_occ = tb_occ + (prev_rd ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        prev_rd = memZ_rd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Load memory, queue the expected vector, pulse done_i for one edge.
    task automatic start(input int x, input int y, input bit shape);
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom_range(0, 65535));
        if (x == 0 || y == 0) n = 0;
        else if (shape) n = x;
        else n = x + y - 1;
        for (int a = 0; a < n; a++) exp_q.push_back({(a == n - 1), mem[a]});
        exp_addr = 0;
        data_ConfigReg = cfg(x, y, shape);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        e0 = cyc;
        clear_rec();
        // Scramble the config; the latched length must be unaffected.
        data_ConfigReg = $urandom;
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL timeout: rd_done not seen within %0d cycles", budget);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        done_i = 1'b0;
        out_ready = 1'b1;
        data_ConfigReg = 32'd0;
        #12;
        total++;
        if ({memZ_addr, memZ_rd, out_data, out_valid, out_last, busy, rd_done} !== 28'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {memZ_addr, memZ_rd, out_data, out_valid, out_last, busy, rd_done});
        end
`ifdef RD_OVERRUN_EN
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_overrun: got %b required 0", overrun);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        start(4, 3, 0);
        run(40);
        total++;
        if (first_rd_t !== e0) begin
            bad++; $display("FAIL full_first_rd: got %0d required %0d", first_rd_t, e0);
        end
        total++;
        if (first_valid_t !== e0 + 2) begin
            bad++; $display("FAIL full_first_valid: got %0d required %0d", first_valid_t, e0 + 2);
        end
        total++;
        if (last_xfer_t !== e0 + 7) begin
            bad++; $display("FAIL full_last_xfer: got %0d required %0d", last_xfer_t, e0 + 7);
        end
        total++;
        if (rd_done_t !== last_xfer_t + 1 || done_cnt !== 1) begin
            bad++; $display("FAIL full_rd_done: got t=%0d n=%0d required t=%0d n=1",
                            rd_done_t, done_cnt, last_xfer_t + 1);
        end
        total++;
        if (rd_cnt !== 6 || xfer_cnt !== 6 || exp_q.size() !== 0) begin
            bad++; $display("FAIL full_counts: got rd=%0d xfer=%0d left=%0d required 6 6 0",
                            rd_cnt, xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int k;
        out_ready = 1'b1;
        start(5, 2, 1);
        k = 0;
        while (done_cnt == 0 && k < 60) begin
            out_ready = (k % 2 == 0);
            step();
            k++;
        end
        out_ready = 1'b1;
        run(10);
        total++;
        if (rd_cnt !== 5 || xfer_cnt !== 5 || exp_q.size() !== 0) begin
            bad++; $display("FAIL stall_counts: got rd=%0d xfer=%0d left=%0d required 5 5 0",
                            rd_cnt, xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        start(7, 0, 0);
        run(10);
        total++;
        if (rd_cnt !== 0 || first_valid_t !== -1) begin
            bad++; $display("FAIL zero_activity: got rd=%0d valid_t=%0d required 0 -1",
                            rd_cnt, first_valid_t);
        end
        total++;
        if (done_cnt !== 1 || rd_done_t !== e0) begin
            bad++; $display("FAIL zero_rd_done: got n=%0d t=%0d required 1 %0d",
                            done_cnt, rd_done_t, e0);
        end
        total++;
        if (busy_low_t < 0 || busy_low_t > e0 + 2) begin
            bad++; $display("FAIL zero_busy: got low at %0d required <= %0d", busy_low_t, e0 + 2);
        end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        start(31, 31, 0);
        run(120);
        total++;
        if (rd_cnt !== 61 || last_addr !== 60) begin
            bad++; $display("FAIL max_reads: got rd=%0d last=%0d required 61 60", rd_cnt, last_addr);
        end
        total++;
        if (xfer_cnt !== 61 || last_xfer_t !== e0 + 62 || exp_q.size() !== 0) begin
            bad++; $display("FAIL max_xfer: got n=%0d t=%0d left=%0d required 61 %0d 0",
                            xfer_cnt, last_xfer_t, exp_q.size(), e0 + 62);
        end
    endtask

    task automatic test_overlap();
        out_ready = 1'b1;
`ifdef RD_OVERRUN_EN
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_early: got %b required 0", overrun);
        end
`endif
        start(4, 3, 0);
        for (int i = 0; i < 6; i++) step();
        data_ConfigReg = cfg(9, 9, 0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        run(40);
        for (int i = 0; i < 5; i++) step();
        total++;
        if (rd_cnt !== 6 || last_addr !== 5 || xfer_cnt !== 6 || exp_q.size() !== 0) begin
            bad++; $display("FAIL overlap_counts: got rd=%0d last=%0d xfer=%0d left=%0d required 6 5 6 0",
                            rd_cnt, last_addr, xfer_cnt, exp_q.size());
        end
        total++;
        if (done_cnt !== 1 || last_xfer_t !== e0 + 7) begin
            bad++; $display("FAIL overlap_timing: got n=%0d t=%0d required 1 %0d",
                            done_cnt, last_xfer_t, e0 + 7);
        end
`ifdef RD_OVERRUN_EN
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set: got %b required 1", overrun);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int k;
        out_ready = 1'b1;
        start(4, 3, 0);
        k = 0;
        while (xfer_cnt < 3 && k < 20) begin
            step();
            k++;
        end
        total++;
        if (xfer_cnt !== 3) begin
            bad++; $display("FAIL midrst_setup: got %0d transfers required 3", xfer_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({memZ_addr, memZ_rd, out_data, out_valid, out_last, busy, rd_done} !== 28'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got %h required 0",
                     {memZ_addr, memZ_rd, out_data, out_valid, out_last, busy, rd_done});
        end
`ifdef RD_OVERRUN_EN
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL midrst_overrun: got %b required 0", overrun);
        end
`endif
        exp_q.delete();
        tb_occ = 0;
        prev_rd = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_rec();
        for (int i = 0; i < 3; i++) step();
        total++;
        if (xfer_cnt !== 0 || first_valid_t !== -1) begin
            bad++; $display("FAIL midrst_stale: got %0d samples after reset required 0", xfer_cnt);
        end
        start(4, 3, 0);
        run(40);
        total++;
        if (first_rd_t !== e0 || rd_cnt !== 6 || xfer_cnt !== 6 || exp_q.size() !== 0) begin
            bad++; $display("FAIL midrst_restart: got t=%0d rd=%0d xfer=%0d left=%0d required %0d 6 6 0",
                            first_rd_t, rd_cnt, xfer_cnt, exp_q.size(), e0);
        end
    endtask

    initial begin
        dataZ = 16'd0;
        clear_rec();
        test_reset();
        test_full();
        test_stall();
        test_zero();
        test_max();
        test_overlap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
